// File: rtl/output_unloader.sv
// Reassembles {mode,rdy,nibble} byte frames into two W-bit words and a mode.
// Optional saturating abort counter on err_count when OUTPUT_UNLOADER_ERRCNT_EN is defined.

// One nibble position of the A/B shadow registers.
module output_unloader_nib_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       we_a,
  input  logic       we_b,
  input  logic [3:0] nib,
  output logic [3:0] a_q,
  output logic [3:0] b_q,
  output logic [3:0] b_nxt
);
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (we_a) a_q <= nib;
      if (we_b) b_q <= nib;
    end
  end

  // The final B nibble lands in word_b on the same edge it is sampled.
  assign b_nxt = we_b ? nib : b_q;
endmodule

module output_unloader #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_byte,
  output logic [W-1:0] word_a,
  output logic [W-1:0] word_b,
  output logic [2:0]   mode_out,
  output logic         frame_valid,
  output logic         frame_err,
  output logic         busy
`ifdef OUTPUT_UNLOADER_ERRCNT_EN
  ,
  output logic [7:0]   err_count
`endif
);
  localparam int NIB = W / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RECV_A, RECV_B} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   idx, idx_d;
  logic [2:0]      cur_mode;
  logic [NIB-1:0]  we_a, we_b;
  logic            commit, abort;

  logic [NIB-1:0][3:0] sh_a, sh_b, b_nxt;

  logic       rdy;
  logic [2:0] mode_in;
  logic [3:0] nib;
  logic       match;

  assign rdy     = in_byte[4];
  assign mode_in = in_byte[7:5];
  assign nib     = in_byte[3:0];
  assign match   = rdy && (mode_in == cur_mode);
  assign busy    = (state != IDLE);

  for (genvar i = 0; i < NIB; i++) begin : g_lane
    output_unloader_nib_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .we_a  (we_a[i]),
      .we_b  (we_b[i]),
      .nib   (nib),
      .a_q   (sh_a[i]),
      .b_q   (sh_b[i]),
      .b_nxt (b_nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= IW'(NIB - 1);
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    we_a    = '0;
    we_b    = '0;
    commit  = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rdy) begin
          we_a[NIB-1] = 1'b1;
          if (NIB > 1) begin
            state_d = RECV_A;
            idx_d   = IW'(NIB - 2);
          end else begin
            state_d = RECV_B;
            idx_d   = IW'(NIB - 1);
          end
        end
      end
      RECV_A: begin
        if (!match) begin
          abort   = 1'b1;
          state_d = IDLE;
          idx_d   = IW'(NIB - 1);
        end else begin
          we_a = NIB'(1) << idx;
          if (idx == '0) begin
            state_d = RECV_B;
            idx_d   = IW'(NIB - 1);
          end else begin
            idx_d = idx - 1'b1;
          end
        end
      end
      RECV_B: begin
        if (!match) begin
          abort   = 1'b1;
          state_d = IDLE;
          idx_d   = IW'(NIB - 1);
        end else begin
          we_b = NIB'(1) << idx;
          if (idx == '0) begin
            commit  = 1'b1;
            state_d = IDLE;
            idx_d   = IW'(NIB - 1);
          end else begin
            idx_d = idx - 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = IW'(NIB - 1);
      end
    endcase
  end

  // The offending byte of an abort never opens a frame: cur_mode only loads from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_mode    <= '0;
      word_a      <= '0;
      word_b      <= '0;
      mode_out    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= commit;
      frame_err   <= abort;
      if (state == IDLE && rdy) cur_mode <= mode_in;
      if (commit) begin
        word_a   <= sh_a;
        word_b   <= b_nxt;
        mode_out <= cur_mode;
      end
    end
  end

`ifdef OUTPUT_UNLOADER_ERRCNT_EN
  // Counts on the abort edge so err_count moves together with the frame_err pulse.
  always_ff @(posedge clk) begin
    if (rst)                              err_count <= '0;
    else if (abort && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`else
  // Error counter not built.
`endif
endmodule

// File: tb/tb_output_unloader.sv
// Randomized + directed bench for output_unloader, scoreboarded against a byte-level frame model.
module tb_output_unloader;
  localparam int W   = 32;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_byte = '0;
  logic [W-1:0] word_a, word_b;
  logic [2:0]   mode_out;
  logic         frame_valid, frame_err, busy;
`ifdef OUTPUT_UNLOADER_ERRCNT_EN
  logic [7:0]   err_count;
`endif

  output_unloader #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_byte     (in_byte),
    .word_a      (word_a),
    .word_b      (word_b),
    .mode_out    (mode_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy)
`ifdef OUTPUT_UNLOADER_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           tag;
    bit           is_err;
    logic [W-1:0] a, b;
    logic [2:0]   m;
  } ev_t;

  typedef struct {
    int           tag;
    bit           busy;
    logic [W-1:0] a, b;
    logic [2:0]   m;
    logic [7:0]   ec;
  } st_t;

  ev_t ev_q[$];
  st_t st_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: collects the nibbles of the frame in flight and rebuilds words arithmetically.
  bit         m_in_frame = 0;
  logic [2:0] m_mode = '0;
  logic [3:0] m_nibs[$];
  logic [W-1:0] h_a = '0, h_b = '0;
  logic [2:0] h_m = '0;
  logic [7:0] m_ec = '0;

  task automatic model(input logic r, input logic [7:0] b, input int tag);
    ev_t e;
    st_t s;
    logic [W-1:0] a, bb;
    if (r) begin
      m_in_frame = 0;
      m_nibs.delete();
      h_a = '0; h_b = '0; h_m = '0; m_ec = '0;
    end else if (!m_in_frame) begin
      if (b[4]) begin
        m_in_frame = 1;
        m_mode = b[7:5];
        m_nibs.delete();
        m_nibs.push_back(b[3:0]);
      end
    end else if (!b[4] || b[7:5] != m_mode) begin
      m_in_frame = 0;
      if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
      e.tag = tag; e.is_err = 1; e.a = '0; e.b = '0; e.m = '0;
      ev_q.push_back(e);
    end else begin
      m_nibs.push_back(b[3:0]);
      if (m_nibs.size() == 2 * NIB) begin
        a = '0; bb = '0;
        for (int i = 0; i < NIB; i++) begin
          a  = (a << 4)  | W'(m_nibs[i]);
          bb = (bb << 4) | W'(m_nibs[NIB + i]);
        end
        h_a = a; h_b = bb; h_m = m_mode;
        m_in_frame = 0;
        e.tag = tag; e.is_err = 0; e.a = a; e.b = bb; e.m = m_mode;
        ev_q.push_back(e);
      end
    end
    s.tag = tag; s.busy = m_in_frame; s.a = h_a; s.b = h_b; s.m = h_m; s.ec = m_ec;
    st_q.push_back(s);
  endtask

  task automatic step(input logic r, input logic [7:0] b);
    @(posedge clk);
    #2;
    rst = r;
    in_byte = b;
    model(r, b, cyc + 1);
  endtask

  function automatic logic [7:0] mk(input logic [2:0] m, input logic rd, input logic [3:0] n);
    return {m, rd, n};
  endfunction

  task automatic send_frame(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = NIB - 1; i >= 0; i--) step(0, mk(m, 1'b1, a[i*4 +: 4]));
    for (int i = NIB - 1; i >= 0; i--) step(0, mk(m, 1'b1, b[i*4 +: 4]));
  endtask

  // Monitor: pops frame events on pulses, per-cycle status every cycle.
  always @(negedge clk) begin
    ev_t e;
    st_t s;
    if (frame_valid === 1'b1 && frame_err === 1'b1) chk("pulse_overlap", 1, 0);
    if (frame_valid === 1'b1 || frame_err === 1'b1) begin
      if (ev_q.size() == 0) begin
        chk("unexpected_pulse", {frame_valid, frame_err}, 0);
      end else begin
        e = ev_q.pop_front();
        chk("pulse_cycle", 64'(cyc), 64'(e.tag));
        chk("pulse_kind", frame_err, e.is_err);
        if (!e.is_err) begin
          chk("word_a", word_a, e.a);
          chk("word_b", word_b, e.b);
          chk("mode_out", mode_out, e.m);
        end
      end
    end
    while (ev_q.size() > 0 && ev_q[0].tag < cyc) begin
      e = ev_q.pop_front();
      chk("missing_pulse", 64'(cyc), 64'(e.tag));
    end
    while (st_q.size() > 0 && st_q[0].tag < cyc) void'(st_q.pop_front());
    if (st_q.size() > 0 && st_q[0].tag == cyc) begin
      s = st_q.pop_front();
      chk("busy", busy, s.busy);
      chk("held_a", word_a, s.a);
      chk("held_b", word_b, s.b);
      chk("held_mode", mode_out, s.m);
`ifdef OUTPUT_UNLOADER_ERRCNT_EN
      chk("err_count", err_count, s.ec);
`endif
    end
  end

  initial begin
    logic [2:0]   md, md2;
    logic [W-1:0] ra, rb;
    logic [7:0]   fb[$];
    int           kind, pos;

    step(1, 8'h00);
    step(1, 8'h00);
    step(0, 8'h00);

    // Directed good frame followed by a zero-gap second frame.
    send_frame(3'd5, 32'h12345678, 32'h9ABCDEF0);
    send_frame(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (3) step(0, 8'h00);

    // rdy drop after 5 bytes, then a good frame.
    for (int i = 1; i <= 5; i++) step(0, mk(3'd5, 1'b1, 4'(i)));
    step(0, 8'h00);
    send_frame(3'd3, 32'hCAFEF00D, 32'h0BADBEEF);

    // Mode change mid-frame; the offending byte must not open a frame.
    step(0, 8'h31);
    step(0, 8'h32);
    step(0, 8'h53);
    repeat (15) step(0, 8'h54);
    step(0, 8'h00);
    step(0, 8'h00);

    // Reset mid-frame, then a good frame.
    for (int i = 0; i < 10; i++) step(0, mk(3'd6, 1'b1, 4'(i)));
    step(1, 8'hB5);
    send_frame(3'd7, 32'h00000001, 32'h80000000);
    step(0, 8'h00);

    // Randomized frames with gaps, aborts and resets.
    for (int f = 0; f < 150; f++) begin
      repeat ($urandom_range(0, 2)) step(0, mk(3'($urandom), 1'b0, 4'($urandom)));
      md = 3'($urandom);
      ra = W'($urandom);
      rb = W'($urandom);
      fb.delete();
      for (int i = NIB - 1; i >= 0; i--) fb.push_back(mk(md, 1'b1, ra[i*4 +: 4]));
      for (int i = NIB - 1; i >= 0; i--) fb.push_back(mk(md, 1'b1, rb[i*4 +: 4]));
      kind = $urandom_range(0, 9);
      pos  = $urandom_range(1, 2 * NIB - 1);
      for (int i = 0; i < 2 * NIB; i++) begin
        if (kind == 0 && i == pos) begin
          md2 = md ^ 3'($urandom_range(1, 7));
          if ($urandom_range(0, 1) == 0) step(0, mk(3'($urandom), 1'b0, 4'($urandom)));
          else                           step(0, mk(md2, 1'b1, 4'($urandom)));
          break;
        end else if (kind == 1 && i == pos) begin
          step(1, fb[i]);
          break;
        end
        step(0, fb[i]);
      end
    end
    step(0, 8'h00);

`ifdef OUTPUT_UNLOADER_ERRCNT_EN
    for (int i = 0; i < 300; i++) begin
      step(0, 8'h91);
      step(0, 8'h00);
    end
    step(1, 8'h00);
    step(0, 8'h00);
`endif

    repeat (4) step(0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("events_drained", 64'(ev_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/output_unloader.md
Name: output_unloader

Overview:
- Receive-side counterpart of the output loader's byte stream.
- Samples an 8-bit stream in which each byte is {mode[2:0], rdy, nibble[3:0]} and reassembles two W-bit words (A then B, most-significant nibble first) plus the 3-bit mode.
- Presents the completed frame with a one-cycle valid strobe.
- Sits at the input boundary of the consuming logic; malformed frames are flagged and discarded.

Parameters:
- W, 32, word width in bits; must be a multiple of 4. NIB = W/4 nibbles per word, 2*NIB bytes per frame.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- in_byte  input  8  stream byte: [7:5] mode, [4] rdy, [3:0] nibble
- word_a  output  W  reassembled word A, held until next good frame
- word_b  output  W  reassembled word B, held until next good frame
- mode_out  output  3  mode of last good frame
- frame_valid  output  1  one-cycle pulse: word_a/word_b/mode_out just updated
- frame_err  output  1  one-cycle pulse: frame aborted
- busy  output  1  high while a frame is partially received (state != IDLE)

Behaviour:
- Single clock domain; reset is synchronous, active-high.
- Reset: state=IDLE; word_a, word_b, mode_out = 0; frame_valid = 0, frame_err = 0; nibble index = NIB-1; shadow registers = 0.
- A byte is a data byte iff in_byte[4]=1; in_byte is sampled every clock, with no stall or backpressure.
- IDLE:
  - rdy=1 -> latch cur_mode=in_byte[7:5]; store the nibble into shadow_a[W-1:W-4]; idx=NIB-2; go to RECV_A.
  - rdy=0 -> stay in IDLE.
- RECV_A, each cycle:
  - rdy=0 or in_byte[7:5]!=cur_mode -> abort.
  - Otherwise write the nibble at shadow_a[idx*4+3:idx*4].
  - If idx==0: idx=NIB-1, go to RECV_B; else idx decrements.
- RECV_B: same checks, writing shadow_b.
  - On idx==0: next edge copies shadow_a -> word_a, {shadow_b with final nibble} -> word_b, cur_mode -> mode_out; frame_valid=1 for exactly one cycle; state=IDLE.
- Latency: frame_valid rises on the clock edge that samples the final (2*NIB-th) byte; outputs are valid in the cycle where frame_valid=1.
- Abort:
  - frame_err pulses 1 cycle; state=IDLE; outputs unchanged.
  - The offending byte is NOT reused as a frame start, even if rdy=1 with a new mode.
  - The next frame starts on a later rdy=1 byte.
- Back-to-back frames: a rdy=1 byte in the cycle immediately after the final byte (state IDLE) starts a new frame. Zero gap cycles are required to be supported.
- Shadow registers are not cleared between frames. Every nibble is overwritten before use.
- Reset mid-frame: partial data is discarded; no frame_valid and no frame_err are emitted.
- frame_valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro: OUTPUT_UNLOADER_ERRCNT_EN.
- Defined:
  - Adds output err_count [7:0].
  - Increments on every frame_err pulse and saturates at 0xFF.
  - Cleared only by rst.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Good frame, mode=5, A=0x12345678, B=0x9ABCDEF0:
  - Bytes 0xB1,0xB2,0xB3,0xB4,0xB5,0xB6,0xB7,0xB8,0xB9,0xBA,0xBB,0xBC,0xBD,0xBE,0xBF,0xB0 on 16 consecutive cycles.
  - Expect: one frame_valid pulse on the 16th edge; word_a=0x12345678, word_b=0x9ABCDEF0, mode_out=5; busy high for cycles 1-15.
- Back-to-back: the above frame, then immediately 16 bytes of mode=2 with A=B=0xFFFFFFFF (0x5F x16).
  - Expect: two frame_valid pulses 16 cycles apart; final mode_out=2, word_a=word_b=0xFFFFFFFF.
- rdy drop: 5 bytes of a valid frame, then 0x00.
  - Expect: frame_err pulse on the 6th edge, busy=0; word_a/word_b/mode_out keep their prior values.
  - Then a full good frame is accepted.
- Mode change mid-frame: 0x31,0x32, then 0x53.
  - Expect: frame_err on the 3rd edge; no frame_valid.
  - 0x53 does not start a frame, so the next 15 bytes yield no frame_valid.
- Reset mid-frame: assert rst for 1 cycle after 10 bytes.
  - Expect: outputs 0, busy=0, no pulses.
  - A subsequent full frame decodes correctly.
- With OUTPUT_UNLOADER_ERRCNT_EN: 300 aborted frames -> err_count=0xFF; rst -> 0x00.
